// File: rtl/drain_pkg.sv
// drain_pkg: shared types and widths for the drain_to_mem write engine.
`default_nettype none
package drain_pkg;
  localparam int MEM_WORD_W = 64;
  localparam int MEM_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    NEXT  = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/drain_to_mem_byte_packer.sv
// byte_packer: LSB-first shift-in of FIFO bytes into one memory word.
`default_nettype none
module byte_packer
  import drain_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [MEM_WORD_W-1:0] word,
  output logic                  full
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  logic [MEM_WORD_W-1:0] shift_q;
  logic [CW-1:0]         count_q;

  // word/full look ahead through the current capture so the final byte can be
  // forwarded to the write register in the same cycle it arrives.
  assign word = capture ? {din, shift_q[MEM_WORD_W-1:DATA_WIDTH]} : shift_q;
  assign full = capture && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (capture) begin
      shift_q <= word;
      count_q <= count_q + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/drain_to_mem.sv
// drain_to_mem: pops DEPTH bytes from each result FIFO in turn, packs them and
// writes one 64-bit word per FIFO over an Avalon-MM master at base+k.
`default_nettype none
module drain_to_mem
  import drain_pkg::*;
#(
  parameter int NUM_FIFOS  = 9,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_ADDR_W-1:0] addr,
  input  logic                  drain,
  input  logic [DATA_WIDTH-1:0] fifoData,
  input  logic [NUM_FIFOS-1:0]  fifoEmpty,
  output logic [NUM_FIFOS-1:0]  fifoRead,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic                  mem_write,
  output logic [MEM_WORD_W-1:0] mem_writedata,
  input  logic                  mem_waitrequest,
  output logic                  busy,
  output logic                  done
);
  if (DEPTH * DATA_WIDTH != MEM_WORD_W) begin : g_bad_cfg
    $error("drain_to_mem: DEPTH*DATA_WIDTH must equal 64");
  end

  localparam int PW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  state_t                state, state_n;
  logic [NUM_FIFOS-1:0]  sel;
  logic [PW-1:0]         pop_cnt;
  logic                  pop, pop_d;
  logic                  pack_clear;
  logic [MEM_WORD_W-1:0] word;
  logic                  full;
  logic                  last_fifo;

  assign last_fifo  = sel[NUM_FIFOS-1];
  assign busy       = (state != IDLE);
  assign pop        = (state == READ) && (pop_cnt < DEPTH_C) && |(sel & ~fifoEmpty);
  assign fifoRead   = pop ? sel : '0;
  assign pack_clear = ((state == IDLE) && drain) || ((state == NEXT) && !last_fifo);

  byte_packer #(
    .DEPTH     (DEPTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .clear  (pack_clear),
    .capture(pop_d),
    .din    (fifoData),
    .word   (word),
    .full   (full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (drain) state_n = READ;
      READ:    if (full) state_n = WRITE;
      WRITE:   if (!mem_waitrequest) state_n = NEXT;
      NEXT:    state_n = last_fifo ? IDLE : READ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel           <= '0;
      pop_cnt       <= '0;
      pop_d         <= 1'b0;
      mem_address   <= '0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
      done          <= 1'b0;
    end else begin
      // fifoData is valid one cycle after the pop, so capture trails pop by one.
      pop_d <= pop;
      if (pop) pop_cnt <= pop_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (drain) begin
            mem_address <= addr;
            done        <= 1'b0;
            sel         <= NUM_FIFOS'(1);
            pop_cnt     <= '0;
          end
        end
        READ: begin
          if (full) begin
            mem_writedata <= word;
            mem_write     <= 1'b1;
          end
        end
        WRITE: begin
          if (!mem_waitrequest) mem_write <= 1'b0;
        end
        NEXT: begin
          if (last_fifo) begin
            done <= 1'b1;
          end else begin
            mem_address <= mem_address + 1'b1;
            sel         <= sel << 1;
            pop_cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: doc/drain_to_mem.md
Name: drain_to_mem

Overview:
- Write-side counterpart of the FIFO fill engine. Drains DEPTH bytes from each of NUM_FIFOS result FIFOs in turn.
- Packs each FIFO's bytes LSB-first into one 64-bit word. Writes that word to memory over the same Avalon-MM master interface (address/write/writedata/waitrequest).
- FIFO k is written to address base+k.
- Sits between the systolic array's output FIFOs and mem_wrapper.

Parameters:
- NUM_FIFOS, 9, number of source FIFOs (one memory word per FIFO).
- DEPTH, 8, bytes popped per FIFO. DEPTH*DATA_WIDTH must equal 64; otherwise elaboration fails via $error.
- DATA_WIDTH, 8, FIFO data width in bits.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- addr  input  32  base word address, sampled when drain is accepted.
- drain  input  1  start request; honoured only in IDLE.
- fifoData  input  DATA_WIDTH  read data of the selected FIFO (external mux), valid exactly 1 cycle after its fifoRead bit.
- fifoEmpty  input  NUM_FIFOS  per-FIFO empty flags.
- fifoRead  output  NUM_FIFOS  one-hot pop strobe to the current FIFO.
- mem_address  output  32  Avalon word address.
- mem_write  output  1  Avalon write request.
- mem_writedata  output  64  Avalon write data.
- mem_waitrequest  input  1  Avalon stall.
- busy  output  1  high whenever state != IDLE.
- done  output  1  sticky completion flag.

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; fifoRead=0, mem_write=0, mem_address=0, mem_writedata=0, done=0, busy=0; all counters cleared.
- Reset mid-operation aborts immediately. mem_write drops the next cycle even while waitrequest=1. Data already popped is discarded.
- States: IDLE, READ, WRITE, NEXT.
- IDLE:
  - On drain=1: latch mem_address<=addr, clear done, fifoSel<=one-hot bit 0, popCnt=capCnt=0, go to READ.
  - drain asserted in any other state is ignored.
- READ:
  - fifoRead[sel]=1 in any cycle where popCnt<DEPTH and fifoEmpty[sel]=0; popCnt increments on each pop.
  - Pops may issue back-to-back.
  - One cycle after each pop, capture: word <= {fifoData, word[63:DATA_WIDTH]}, capCnt++. The first popped byte therefore ends in bits [7:0].
  - An empty FIFO stalls READ indefinitely; there is no timeout.
  - Never pops more than DEPTH bytes from one FIFO.
  - When capCnt reaches DEPTH, go to WRITE; register mem_writedata<=word and mem_write<=1.
- WRITE:
  - Hold mem_address, mem_writedata and mem_write stable while mem_waitrequest=1.
  - Transfer completes on a cycle with mem_write=1 and mem_waitrequest=0. Then mem_write<=0, go to NEXT.
- NEXT:
  - If fifoSel[NUM_FIFOS-1]: done<=1, go to IDLE.
  - Otherwise: mem_address<=mem_address+1 (32-bit wrap, 0xFFFFFFFF->0), fifoSel<<=1, clear counters, go to READ.
- Latency with no empties and no waitrequest:
  - READ entered at cycle T; pops at T..T+DEPTH-1; mem_write high at T+DEPTH+1 for 1 cycle.
  - NEXT at T+DEPTH+2; next READ at T+DEPTH+3.
  - One FIFO = DEPTH+3 cycles; full drain = NUM_FIFOS*(DEPTH+3)+1 cycles from drain to done.
- done stays high until the next accepted drain.
- busy is combinational from state.

Decomposition:
- Package drain_pkg: state enum (IDLE, READ, WRITE, NEXT), localparam MEM_WORD_W=64, localparam MEM_ADDR_W=32.
- Sub-module byte_packer: shift-in register plus capture counter. Inputs: clear, capture strobe, byte. Outputs: word, full. Top level holds the FSM, the pop logic and the Avalon master.

Test Plan:
- Basic drain: addr=0x100, FIFO k preloaded with bytes 8k+0..8k+7 -> nine writes at 0x100..0x108; word 0 = 0x0706050403020100; done after 100 cycles (NUM_FIFOS=9, DEPTH=8); fifoRead never exceeds 8 pulses per FIFO.
- Waitrequest stall: hold mem_waitrequest=1 for 5 cycles on the 3rd write -> mem_address=addr+2 and mem_writedata held constant throughout; exactly one accepted transfer; no extra pops.
- Empty stall: FIFO 4 empty after its 3rd byte for 10 cycles -> no fifoRead during the gap; resumes; word 4 is still correct and ordered.
- Reset mid-op: assert rst during the WRITE of FIFO 2 with waitrequest=1 -> next cycle mem_write=0, busy=0, done=0; a subsequent drain restarts from FIFO 0 at the new addr.
- Address wrap / ignored start: addr=0xFFFFFFFE -> writes to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, ...; a drain pulse while busy causes no restart and no addr relatch.
